// File: rtl/ltl_mon_pkg.sv
// Shared definitions for the LTL monitor report path: default widths and the
// packed layout of a timestamped report entry.
package ltl_mon_pkg;

    localparam int MON_NUM_REPORTS = 4;
    localparam int MON_TS_W        = 32;

    typedef struct packed {
        logic [MON_TS_W-1:0]        ts;
        logic [MON_NUM_REPORTS-1:0] rpt;
    } mon_report_entry_t;

endpackage

// File: rtl/ltl_mon_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is always
// visible on dout; full/empty are derived from the occupancy counter.
module ltl_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // When full, a push is only taken alongside a pop; the write lands in the
    // slot being vacated, whose old contents are already on dout this cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ltl_report_collector.sv
// Timestamps automaton report activity, buffers it in a FWFT FIFO for the
// trace/CSR side, and keeps sticky status, overflow, drop count and irq.
module ltl_report_collector
    import ltl_mon_pkg::*;
#(
    parameter int NUM_REPORTS = MON_NUM_REPORTS,
    parameter int DEPTH       = 8,
    parameter int TS_W        = MON_TS_W,
    parameter int DROP_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [NUM_REPORTS-1:0]   report,
    input  logic                     clear_sticky,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_REPORTS-1:0]   out_report,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [NUM_REPORTS-1:0]   sticky,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     irq
);

    localparam int ENTRY_W = NUM_REPORTS + TS_W;

    logic [TS_W-1:0]        ts_cnt;
    logic [ENTRY_W-1:0]     fifo_din;
    logic [ENTRY_W-1:0]     fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push_req;
    logic                   pop;
    logic                   drop;
    logic [NUM_REPORTS-1:0] seen;

    always_comb begin
        push_req = run && (|report);
        pop      = out_valid && out_ready;
        drop     = push_req && fifo_full && !pop;
        seen     = run ? report : '0;
        fifo_din = {report, ts_cnt};
    end

    ltl_mon_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign out_valid  = !fifo_empty;
    assign out_report = out_valid ? fifo_dout[ENTRY_W-1:TS_W] : '0;
    assign out_ts     = out_valid ? fifo_dout[TS_W-1:0] : '0;
    assign irq        = (|sticky) || overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
        end else if (run) begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // Same-cycle events take priority over clear_sticky: a clear restarts the
    // status from whatever happened in that cycle rather than from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_sticky) begin
            sticky     <= seen;
            overflow   <= drop;
            drop_count <= drop ? DROP_W'(1) : '0;
        end else begin
            sticky   <= sticky | seen;
            overflow <= overflow | drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed self-checking bench for ltl_report_collector with default parameters.
module tb_ltl_report_collector;
    import ltl_mon_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  report;
    logic        clear_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_report;
    logic [31:0] out_ts;
    logic [3:0]  occupancy;
    logic [3:0]  sticky;
    logic        overflow;
    logic [15:0] drop_count;
    logic        irq;

    int checks = 0;
    int errors = 0;
    mon_report_entry_t exp_e;

    ltl_report_collector #(
        .NUM_REPORTS (4),
        .DEPTH       (8),
        .TS_W        (32),
        .DROP_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .report       (report),
        .clear_sticky (clear_sticky),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_report   (out_report),
        .out_ts       (out_ts),
        .occupancy    (occupancy),
        .sticky       (sticky),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input string tag, input mon_report_entry_t e);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_rpt"}, 32'(out_report), 32'(e.rpt));
        check({tag, "_ts"}, out_ts, e.ts);
    endtask

    task automatic check_status(input string tag, input logic [3:0] s, input logic ov,
                                input logic [15:0] dc, input logic [3:0] occ);
        check({tag, "_sticky"}, 32'(sticky), 32'(s));
        check({tag, "_overflow"}, 32'(overflow), 32'(ov));
        check({tag, "_drops"}, 32'(drop_count), 32'(dc));
        check({tag, "_occ"}, 32'(occupancy), 32'(occ));
        check({tag, "_irq"}, 32'(irq), 32'((|s) | ov));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; report = '0; clear_sticky = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rpt", 32'(out_report), 32'd0);
        check("rst_ts", out_ts, 32'd0);
        check_status("rst", 4'b0000, 1'b0, 16'd0, 4'd0);

        // Counter advances 0..4 with no reports, report fires at counter 5
        run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        report = 4'b0010;
        tick();
        exp_e = '{ts: 32'd5, rpt: 4'b0010};
        check_entry("first", exp_e);
        check_status("first", 4'b0010, 1'b0, 16'd0, 4'd1);

        // Pop while paused; then three paused cycles with all reports active
        run = 1'b0; report = '0; out_ready = 1'b1;
        tick();
        check("pop1_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0; report = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        check_status("paused", 4'b0010, 1'b0, 16'd0, 4'd0);
        check("paused_valid", 32'(out_valid), 32'd0);
        run = 1'b1; report = 4'b0100;
        tick();
        exp_e = '{ts: 32'd6, rpt: 4'b0100};
        check_entry("resume", exp_e);
        check_status("resume", 4'b0110, 1'b0, 16'd0, 4'd1);
        run = 1'b0; report = '0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fresh start: ten pushes into an eight-deep FIFO with no consumer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_status("rst2", 4'b0000, 1'b0, 16'd0, 4'd0);
        run = 1'b1; report = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        check_status("ovf", 4'b0001, 1'b1, 16'd2, 4'd8);
        run = 1'b0; report = '0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_e = '{ts: 32'(i), rpt: 4'b0001};
            check_entry("drain", exp_e);
            tick();
        end
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_rpt", 32'(out_report), 32'd0);
        check("drained_ts", out_ts, 32'd0);
        check("drained_occ", 32'(occupancy), 32'd0);

        // Counter is 10: refill to full (ts 10..17), then push and pop together
        out_ready = 1'b0; run = 1'b1; report = 4'b0001;
        for (int i = 0; i < 8; i++) tick();
        check("refill_occ", 32'(occupancy), 32'd8);
        report = 4'b1000; out_ready = 1'b1;
        tick();
        check_status("fullpp", 4'b1001, 1'b1, 16'd2, 4'd8);
        run = 1'b0; report = '0;
        for (int i = 0; i < 7; i++) begin
            exp_e = '{ts: 32'(11 + i), rpt: 4'b0001};
            check_entry("fpdrain", exp_e);
            tick();
        end
        exp_e = '{ts: 32'd18, rpt: 4'b1000};
        check_entry("fplast", exp_e);
        tick();
        check("fpempty_valid", 32'(out_valid), 32'd0);

        // Counter is 19: fill again (ts 19..26), then clear coincides with a drop
        out_ready = 1'b0; run = 1'b1; report = 4'b0001;
        for (int i = 0; i < 8; i++) tick();
        report = 4'b0100; clear_sticky = 1'b1;
        tick();
        check_status("clr_evt", 4'b0100, 1'b1, 16'd1, 4'd8);
        run = 1'b0; report = '0;
        tick();
        clear_sticky = 1'b0;
        check_status("clr_lone", 4'b0000, 1'b0, 16'd0, 4'd8);
        exp_e = '{ts: 32'd19, rpt: 4'b0001};
        check_entry("clr_head", exp_e);

        // Leave three entries, then reset discards them and zeroes the counter
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        check("pre_rst_occ", 32'(occupancy), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check_status("midrst", 4'b0000, 1'b0, 16'd0, 4'd0);
        run = 1'b1; report = 4'b0010;
        tick();
        exp_e = '{ts: 32'd0, rpt: 4'b0010};
        check_entry("post_rst", exp_e);
        check("post_rst_occ", 32'(occupancy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
